muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide operate on magnitudes; the sign is fixed up in a final cycle.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flush,
  output logic         busy,
  output logic         stall,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic           spec_q, spec_d;
  logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [N-1:0]   result_q, result_d;

  // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; only MUL/MULH/DIV/REM treat rs2 as signed.
  function automatic logic a_signed(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  endfunction

  function automatic logic b_signed(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  endfunction

  // Magnitudes of the incoming operands, used to seed the datapath on accept.
  logic         in_neg_a, in_neg_b, in_spec;
  logic [N-1:0] in_mag_a, in_mag_b;

  always_comb begin
    in_neg_a = a_signed(funct3) & A[N-1];
    in_neg_b = b_signed(funct3) & B[N-1];
    in_mag_a = in_neg_a ? (~A + 1'b1) : A;
    in_mag_b = in_neg_b ? (~B + 1'b1) : B;
    in_spec  = funct3[2] && ((B == '0) ||
               (!funct3[0] && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1)));
  end

  // Latched operand signs/magnitudes feed the iteration and the fix-up.
  logic         neg_a, neg_b;
  logic [N-1:0] mag_a, mag_b;

  always_comb begin
    neg_a = a_signed(op_q) & a_q[N-1];
    neg_b = b_signed(op_q) & b_q[N-1];
    mag_a = neg_a ? (~a_q + 1'b1) : a_q;
    mag_b = neg_b ? (~b_q + 1'b1) : b_q;
  end

  // One iteration: hi holds the partial product / partial remainder, lo the multiplier / dividend bits.
  logic [N:0] mul_sum, div_rs, div_diff;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a} : '0);
    div_rs   = {hi_q, lo_q[N-1]};
    div_diff = div_rs - {1'b0, mag_b};
  end

  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem, fix_res;

  always_comb begin
    prod    = {hi_q, lo_q};
    quo     = lo_q;
    rem     = hi_q;
    fix_res = '0;
    if (neg_a ^ neg_b) prod = ~prod + 1'b1;
    if (neg_a ^ neg_b) quo  = ~quo + 1'b1;
    if (neg_a)         rem  = ~rem + 1'b1;
    if (spec_q) begin
      // Divide-by-zero and signed overflow have architecturally fixed results.
      if (b_q == '0) fix_res = op_q[1] ? a_q : '1;
      else           fix_res = op_q[1] ? '0  : a_q;
    end else if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod[N-1:0] : prod[2*N-1:N];
    end else begin
      fix_res = op_q[1] ? rem : quo;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    spec_d   = spec_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = A;
            b_d     = B;
            op_d    = funct3;
            spec_d  = in_spec;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = funct3[2] ? in_mag_a : in_mag_b;
            state_d = in_spec ? FIX : CALC;
          end
        end
        CALC: begin
          if (!op_q[2]) begin
            hi_d = mul_sum[N:1];
            lo_d = {mul_sum[0], lo_q[N-1:1]};
          end else if (!div_diff[N]) begin
            hi_d = div_diff[N-1:0];
            lo_d = {lo_q[N-2:0], 1'b1};
          end else begin
            hi_d = div_rs[N-1:0];
            lo_d = {lo_q[N-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) state_d = FIX;
        end
        FIX: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      spec_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      spec_q   <= spec_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign stall  = start | busy;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a monitor pops them on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] A, B;
  logic        busy, stall, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  muldiv_unit #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .A(A), .B(B),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got result 0x%08h expected no done", result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("result", result, e);
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm);
    bit seen = 0;
    bit bz = 0;
    @(negedge clk);
    funct3 = f; A = a; B = b; start = 1'b1;
    exp_q.push_back(exp);
    #1 chk({nm, "_stall"}, {31'd0, stall}, 32'd1);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (!busy) bz = 1;
      if (done) begin
        chk({nm, "_latency"}, n, lat);
        seen = 1;
        break;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_busy_window"}, {31'd0, bz}, 32'd0);
    @(negedge clk);
    chk({nm, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_done",   {31'd0, done},  32'd0);
    chk("rst_stall",  {31'd0, stall}, 32'd0);
    chk("rst_result", result,         32'd0);
    rst_n = 1'b1;

    do_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul");
    do_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh");
    do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu");
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu");
    do_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div");
    do_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem");
    do_op(3'b101, 32'd100,      32'd7,        32'd14,       34, "divu");
    do_op(3'b111, 32'd100,      32'd7,        32'd2,        34, "remu");
    do_op(3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 2,  "divu_by0");
    do_op(3'b110, 32'h1234,     32'd0,        32'h1234,     2,  "rem_by0");
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  "div_ovf");
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  "rem_ovf");

    // Operand changes and a second start while busy must be ignored.
    @(negedge clk);
    funct3 = 3'b000; A = 32'd7; B = 32'hFFFFFFFD; start = 1'b1;
    exp_q.push_back(32'hFFFFFFEB);
    seen = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) begin A = 32'd123; B = 32'd456; funct3 = 3'b011; end
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
      if (done) begin
        chk("ignore_latency", n, 34);
        seen = 1;
        break;
      end
    end
    if (!seen) chk("ignore_timeout", 32'd0, 32'd1);
    repeat (40) @(negedge clk);

    // Flush mid-operation: back to idle, no done, result held.
    funct3 = 3'b011; A = 32'd5; B = 32'd6; start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 20) flush = 1'b1;
      if (n == 21) begin
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
      end
    end
    chk("flush_result_held", result, 32'hFFFFFFEB);

    // Flush together with start: nothing accepted.
    funct3 = 3'b101; A = 32'd9; B = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset during CALC.
    funct3 = 3'b100; A = 32'd50; B = 32'd5; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    chk("midrst_done",   {31'd0, done}, 32'd0);
    chk("midrst_result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b101, 32'd9, 32'd3, 32'd3, 34, "divu_after_rst");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
